// File: rtl/control_sequencer_pkg.sv
// cpu_defs: shared opcodes, IR field positions, sequencer state codes and ALUop bit indices.
package cpu_defs;
  localparam int OPC_LSB = 27;
  localparam int OPC_W = 5;
  localparam int RA_LSB = 23;
  localparam int RB_LSB = 19;
  localparam int RC_LSB = 15;
  localparam int REG_W = 4;
  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_SHR = 5'b00101;
  localparam logic [4:0] OP_SHL = 5'b00110;
  localparam logic [4:0] OP_ROR = 5'b00111;
  localparam logic [4:0] OP_ROL = 5'b01000;
  localparam logic [4:0] OP_AND = 5'b01001;
  localparam logic [4:0] OP_OR = 5'b01010;
  localparam logic [4:0] OP_MUL = 5'b01110;
  localparam logic [4:0] OP_DIV = 5'b01111;
  localparam logic [4:0] OP_NEG = 5'b10000;
  localparam logic [4:0] OP_NOT = 5'b10001;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;
  localparam logic [3:0] S_RESET = 4'd0;
  localparam logic [3:0] S_T0 = 4'd1;
  localparam logic [3:0] S_T1 = 4'd2;
  localparam logic [3:0] S_T2 = 4'd3;
  localparam logic [3:0] S_T3 = 4'd4;
  localparam logic [3:0] S_T4 = 4'd5;
  localparam logic [3:0] S_T5 = 4'd6;
  localparam logic [3:0] S_T6 = 4'd7;
  localparam logic [3:0] S_HALT = 4'd8;
  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_MUL = 2;
  localparam int ALU_DIV = 3;
  localparam int ALU_SHR = 4;
  localparam int ALU_SHL = 5;
  localparam int ALU_ROR = 6;
  localparam int ALU_ROL = 7;
  localparam int ALU_AND = 8;
  localparam int ALU_OR = 9;
  localparam int ALU_NEG = 10;
  localparam int ALU_NOT = 11;
  typedef enum logic [2:0] {
    CLS_ALU3, CLS_MULDIV, CLS_UNARY, CLS_MFHI, CLS_MFLO, CLS_NOP, CLS_HALT, CLS_ILLEGAL
  } op_class_t;
endpackage

// File: rtl/control_sequencer_ir_decoder.sv
// ir_decoder: IR word -> opcode class, one-hot register selects and ALUop vector.
module ir_decoder import cpu_defs::*; #(
  parameter int BITS = 32,
  parameter int REGISTERS = 16
) (
  input  logic [BITS-1:0]      IRVal,
  output op_class_t            cls,
  output logic [REGISTERS-1:0] ra,
  output logic [REGISTERS-1:0] rb,
  output logic [REGISTERS-1:0] rc,
  output logic [11:0]          alu
);
  logic unused_ir;
  assign unused_ir = ^IRVal[RC_LSB-1:0];
  assign ra = REGISTERS'(1) << IRVal[RA_LSB +: REG_W];
  assign rb = REGISTERS'(1) << IRVal[RB_LSB +: REG_W];
  assign rc = REGISTERS'(1) << IRVal[RC_LSB +: REG_W];
  always_comb begin
    cls = CLS_ILLEGAL;
    alu = '0;
    case (IRVal[OPC_LSB +: OPC_W])
      OP_ADD:  begin cls = CLS_ALU3;   alu[ALU_ADD] = 1'b1; end
      OP_SUB:  begin cls = CLS_ALU3;   alu[ALU_SUB] = 1'b1; end
      OP_SHR:  begin cls = CLS_ALU3;   alu[ALU_SHR] = 1'b1; end
      OP_SHL:  begin cls = CLS_ALU3;   alu[ALU_SHL] = 1'b1; end
      OP_ROR:  begin cls = CLS_ALU3;   alu[ALU_ROR] = 1'b1; end
      OP_ROL:  begin cls = CLS_ALU3;   alu[ALU_ROL] = 1'b1; end
      OP_AND:  begin cls = CLS_ALU3;   alu[ALU_AND] = 1'b1; end
      OP_OR:   begin cls = CLS_ALU3;   alu[ALU_OR]  = 1'b1; end
      OP_MUL:  begin cls = CLS_MULDIV; alu[ALU_MUL] = 1'b1; end
      OP_DIV:  begin cls = CLS_MULDIV; alu[ALU_DIV] = 1'b1; end
      OP_NEG:  begin cls = CLS_UNARY;  alu[ALU_NEG] = 1'b1; end
      OP_NOT:  begin cls = CLS_UNARY;  alu[ALU_NOT] = 1'b1; end
      OP_MFHI: cls = CLS_MFHI;
      OP_MFLO: cls = CLS_MFLO;
      OP_NOP:  cls = CLS_NOP;
      OP_HALT: cls = CLS_HALT;
      default: ;
    endcase
  end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute control for the bus datapath.
// Define CTRL_ILLEGAL_TRAP_EN to halt on illegal opcodes and raise a sticky Illegal flag.
module control_sequencer import cpu_defs::*; #(
  parameter int BITS = 32,
  parameter int REGISTERS = 16
) (
  input  logic                 Clock,
  input  logic                 reset,
  input  logic                 Stop,
  input  logic [BITS-1:0]      IRVal,
  output logic                 Run,
  output logic                 Clear,
  output logic                 PCout,
  output logic                 MDRout,
  output logic                 Zlowout,
  output logic                 Zhighout,
  output logic                 HIout,
  output logic                 LOout,
  output logic                 PCin,
  output logic                 IRin,
  output logic                 RYin,
  output logic                 RZin,
  output logic                 MARin,
  output logic                 HIin,
  output logic                 LOin,
  output logic                 MDRin,
  output logic                 IncPC,
  output logic                 Read,
  output logic [REGISTERS-1:0] GPRin,
  output logic [REGISTERS-1:0] GPRout,
  output logic [11:0]          ALUop,
  output logic                 Illegal
);
  op_class_t cls;
  logic [REGISTERS-1:0] ra, rb, rc;
  logic [11:0] alu;
  logic [3:0] state, state_nx;
  logic t0, t1, t2, t3, t4, t5, t6, alu3, muldiv, unary, ill, last, halt_now;
  ir_decoder #(.BITS(BITS), .REGISTERS(REGISTERS)) u_dec (
    .IRVal(IRVal), .cls(cls), .ra(ra), .rb(rb), .rc(rc), .alu(alu)
  );
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
  always_ff @(posedge Clock or negedge reset)
    if (!reset) Illegal <= 1'b0;
    else if (t3 && ill) Illegal <= 1'b1;
`else
  localparam logic TRAP = 1'b0;
  assign Illegal = 1'b0;
`endif
  assign {t0, t1, t2, t3} = {state == S_T0, state == S_T1, state == S_T2, state == S_T3};
  assign {t4, t5, t6} = {state == S_T4, state == S_T5, state == S_T6};
  assign alu3 = cls == CLS_ALU3;
  assign muldiv = cls == CLS_MULDIV;
  assign unary = cls == CLS_UNARY;
  assign ill = cls == CLS_ILLEGAL;
  // Stop is honoured only here, so a running instruction always completes.
  assign last = (t3 && (cls == CLS_MFHI || cls == CLS_MFLO || cls == CLS_NOP || (!TRAP && ill)))
              || (t4 && unary) || (t5 && alu3) || (t6 && muldiv);
  assign halt_now = t3 && (cls == CLS_HALT || (TRAP && ill));
  assign state_nx = (state == S_HALT || halt_now || (last && Stop)) ? S_HALT
                  : last ? S_T0 : state + 4'd1;
  always_ff @(posedge Clock or negedge reset)
    if (!reset) state <= S_RESET;
    else state <= state_nx;
  assign Run = t0 | t1 | t2 | t3 | t4 | t5 | t6;
  assign Clear = state == S_RESET;
  assign {PCout, MARin, IncPC} = {3{t0}};
  assign {PCin, Read, MDRin} = {3{t1}};
  assign {MDRout, IRin} = {2{t2}};
  assign RYin = t3 && (alu3 || muldiv);
  assign RZin = t0 || (t4 && (alu3 || muldiv)) || (t3 && unary);
  assign Zlowout = t1 || (t5 && (alu3 || muldiv)) || (t4 && unary);
  assign {Zhighout, HIin} = {2{t6 && muldiv}};
  assign LOin = t5 && muldiv;
  assign HIout = t3 && cls == CLS_MFHI;
  assign LOout = t3 && cls == CLS_MFLO;
  assign GPRout = (t3 && (alu3 || unary)) ? rb
                : (t3 && muldiv) ? ra
                : (t4 && alu3) ? rc
                : (t4 && muldiv) ? rb : '0;
  assign GPRin = ((t5 && alu3) || (t4 && unary) || HIout || LOout) ? ra : '0;
  assign ALUop = ((t4 && (alu3 || muldiv)) || (t3 && unary)) ? alu : '0;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: table-driven instruction walk plus reset, Stop and illegal-opcode sequences.
module tb_control_sequencer;
  logic Clock = 1'b0, reset = 1'b1, Stop = 1'b0;
  logic [31:0] IRVal = '0;
  logic Run, Clear, PCout, MDRout, Zlowout, Zhighout, HIout, LOout;
  logic PCin, IRin, RYin, RZin, MARin, HIin, LOin, MDRin, IncPC, Read, Illegal;
  logic [15:0] GPRin, GPRout;
  logic [11:0] ALUop;
  logic [18:0] ctl;
  int checks = 0, errors = 0;
  control_sequencer dut (
    .Clock(Clock), .reset(reset), .Stop(Stop), .IRVal(IRVal), .Run(Run), .Clear(Clear),
    .PCout(PCout), .MDRout(MDRout), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIout(HIout),
    .LOout(LOout), .PCin(PCin), .IRin(IRin), .RYin(RYin), .RZin(RZin), .MARin(MARin),
    .HIin(HIin), .LOin(LOin), .MDRin(MDRin), .IncPC(IncPC), .Read(Read), .GPRin(GPRin),
    .GPRout(GPRout), .ALUop(ALUop), .Illegal(Illegal)
  );
  always #5 Clock = ~Clock;
  assign ctl = {Run, Clear, PCout, MDRout, Zlowout, Zhighout, HIout, LOout, PCin, IRin,
                RYin, RZin, MARin, HIin, LOin, MDRin, IncPC, Read, Illegal};
  localparam logic [18:0] RUN = 19'd1 << 18, CLR = 19'd1 << 17, PCO = 19'd1 << 16;
  localparam logic [18:0] MDRO = 19'd1 << 15, ZLO = 19'd1 << 14, ZHO = 19'd1 << 13;
  localparam logic [18:0] HIO = 19'd1 << 12, LOO = 19'd1 << 11, PCI = 19'd1 << 10;
  localparam logic [18:0] IRI = 19'd1 << 9, RYI = 19'd1 << 8, RZI = 19'd1 << 7;
  localparam logic [18:0] MARI = 19'd1 << 6, HII = 19'd1 << 5, LOI = 19'd1 << 4;
  localparam logic [18:0] MDRI = 19'd1 << 3, INC = 19'd1 << 2, RD = 19'd1 << 1, ILL = 19'd1;
  localparam logic [18:0] F0 = RUN | PCO | MARI | INC | RZI;
  localparam logic [18:0] F1 = RUN | ZLO | PCI | RD | MDRI;
  localparam logic [18:0] F2 = RUN | MDRO | IRI;
  localparam logic [31:0] I_AND = 32'h4A920000, I_MUL = 32'h71B00000, I_NOT = 32'h8B880000;
  localparam logic [31:0] I_HALT = 32'hD0000000, I_BAD = 32'hF8000000;
  typedef struct {
    logic [31:0] ir;
    logic        stop;
    logic [18:0] c;
    logic [15:0] gi;
    logic [15:0] go;
    logic [11:0] al;
  } vec_t;
  vec_t tbl[$];
  function automatic logic [31:0] mk(logic [4:0] op, logic [3:0] a, logic [3:0] b, logic [3:0] c);
    return {op, a, b, c, 15'd0};
  endfunction
  function automatic void add(logic [31:0] ir, logic [18:0] c, logic [15:0] gi, logic [15:0] go, logic [11:0] al);
    tbl.push_back('{ir, 1'b0, c, gi, go, al});
  endfunction
  function automatic void fetch(logic [31:0] ir);
    add(ir, F0, 0, 0, 0);
    add(ir, F1, 0, 0, 0);
    add(ir, F2, 0, 0, 0);
  endfunction
  task automatic chk(input string nm, input logic [18:0] c, input logic [15:0] gi, input logic [15:0] go, input logic [11:0] al);
    checks++;
    if ({ctl, GPRin, GPRout, ALUop} !== {c, gi, go, al}) begin
      errors++;
      $display("FAIL %s: got ctl=%h gin=%h gout=%h alu=%h, expected ctl=%h gin=%h gout=%h alu=%h",
               nm, ctl, GPRin, GPRout, ALUop, c, gi, go, al);
    end
  endtask
  task automatic step(input string nm, input logic [31:0] ir, input logic st, input logic [18:0] c, input logic [15:0] gi, input logic [15:0] go, input logic [11:0] al);
    @(negedge Clock);
    IRVal = ir;
    Stop = st;
    #1 chk(nm, c, gi, go, al);
  endtask
  task automatic do_reset();
    reset = 1'b0;
    #1 chk("rst_low", CLR, 0, 0, 0);
    @(negedge Clock);
    reset = 1'b1;
    #1 chk("rst_release", CLR, 0, 0, 0);
  endtask
  initial begin
    fetch(I_AND);
    add(I_AND, RUN | RYI, 0, 16'h0004, 0);
    add(I_AND, RUN | RZI, 0, 16'h0010, 12'h100);
    add(I_AND, RUN | ZLO, 16'h0020, 0, 0);
    fetch(mk(5'b00100, 1, 2, 3));
    add(mk(5'b00100, 1, 2, 3), RUN | RYI, 0, 16'h0004, 0);
    add(mk(5'b00100, 1, 2, 3), RUN | RZI, 0, 16'h0008, 12'h002);
    add(mk(5'b00100, 1, 2, 3), RUN | ZLO, 16'h0002, 0, 0);
    fetch(I_MUL);
    add(I_MUL, RUN | RYI, 0, 16'h0008, 0);
    add(I_MUL, RUN | RZI, 0, 16'h0040, 12'h004);
    add(I_MUL, RUN | ZLO | LOI, 0, 0, 0);
    add(I_MUL, RUN | ZHO | HII, 0, 0, 0);
    fetch(mk(5'b01111, 2, 15, 0));
    add(mk(5'b01111, 2, 15, 0), RUN | RYI, 0, 16'h0004, 0);
    add(mk(5'b01111, 2, 15, 0), RUN | RZI, 0, 16'h8000, 12'h008);
    add(mk(5'b01111, 2, 15, 0), RUN | ZLO | LOI, 0, 0, 0);
    add(mk(5'b01111, 2, 15, 0), RUN | ZHO | HII, 0, 0, 0);
    fetch(I_NOT);
    add(I_NOT, RUN | RZI, 0, 16'h0002, 12'h800);
    add(I_NOT, RUN | ZLO, 16'h0080, 0, 0);
    fetch(mk(5'b10000, 15, 14, 0));
    add(mk(5'b10000, 15, 14, 0), RUN | RZI, 0, 16'h4000, 12'h400);
    add(mk(5'b10000, 15, 14, 0), RUN | ZLO, 16'h8000, 0, 0);
    fetch(mk(5'b10111, 9, 0, 0));
    add(mk(5'b10111, 9, 0, 0), RUN | HIO, 16'h0200, 0, 0);
    fetch(mk(5'b11000, 0, 0, 0));
    add(mk(5'b11000, 0, 0, 0), RUN | LOO, 16'h0001, 0, 0);
    fetch(mk(5'b11001, 3, 4, 5));
    add(mk(5'b11001, 3, 4, 5), RUN, 0, 0, 0);
    fetch(I_HALT);
    add(I_HALT, RUN, 0, 0, 0);
    for (int i = 0; i < 10; i++) add(I_HALT, 0, 0, 0, 0);
    #1 reset = 1'b0;
    #1 chk("reset_async", CLR, 0, 0, 0);
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    reset = 1'b1;
    #1 chk("reset_state", CLR, 0, 0, 0);
    foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i].ir, tbl[i].stop, tbl[i].c, tbl[i].gi, tbl[i].go, tbl[i].al);
    do_reset();
    step("a_t0", I_AND, 0, F0, 0, 0, 0);
    step("a_t1", I_AND, 0, F1, 0, 0, 0);
    step("a_t2", I_AND, 0, F2, 0, 0, 0);
    step("a_t3", I_AND, 0, RUN | RYI, 0, 16'h0004, 0);
    step("a_t4", I_AND, 0, RUN | RZI, 0, 16'h0010, 12'h100);
    #2 reset = 1'b0;
    #1 chk("rst_mid_t4", CLR, 0, 0, 0);
    @(negedge Clock);
    #1 chk("rst_held", CLR, 0, 0, 0);
    reset = 1'b1;
    #1 chk("rst_one_cycle", CLR, 0, 0, 0);
    step("rst_t0", I_AND, 0, F0, 0, 0, 0);
    step("s_t1", I_AND, 0, F1, 0, 0, 0);
    step("s_t2", I_AND, 0, F2, 0, 0, 0);
    step("s_t3", I_AND, 0, RUN | RYI, 0, 16'h0004, 0);
    step("s_t4", I_AND, 1, RUN | RZI, 0, 16'h0010, 12'h100);
    step("s_t5", I_AND, 1, RUN | ZLO, 16'h0020, 0, 0);
    step("s_halt", I_AND, 0, 0, 0, 0, 0);
    step("s_halt2", I_AND, 0, 0, 0, 0, 0);
    do_reset();
    step("i_t0", I_BAD, 0, F0, 0, 0, 0);
    step("i_t1", I_BAD, 0, F1, 0, 0, 0);
    step("i_t2", I_BAD, 0, F2, 0, 0, 0);
    step("i_t3", I_BAD, 0, RUN, 0, 0, 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
    step("i_trap", I_BAD, 0, ILL, 0, 0, 0);
    step("i_sticky", I_BAD, 0, ILL, 0, 0, 0);
    do_reset();
`else
    step("i_next_t0", I_BAD, 0, F0, 0, 0, 0);
    step("i_next_t1", I_BAD, 0, F1, 0, 0, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
